// File: rtl/reg_wr_arbiter_pkg.sv
// Shared types and defaults for the decode-stage register-file write arbiter.
package reg_wr_arbiter_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } arb_state_e;

  localparam int DEF_MAX_WAIT = 4;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/reg_wr_arbiter.sv
// Two-writer arbiter for the register-file write port: writeback has priority,
// aux is protected from starvation by a stall request after MAX_WAIT blocked cycles.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int N_REGS   = 8,
  parameter  int MAX_WAIT = DEF_MAX_WAIT,
  localparam int AW       = $clog2(N_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             aux_valid,
  input  logic [AW-1:0]    aux_addr,
  input  logic [WIDTH-1:0] aux_data,
  output logic             aux_ready,
  output logic             stall_req,
  output logic             RegWrite,
  output logic [AW-1:0]    write_address,
  output logic [WIDTH-1:0] write_data
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  arb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             aux_xfer;
  logic             aux_blocked;

  assign aux_ready   = aux_valid && !wb_valid;
  assign aux_xfer    = aux_valid && aux_ready;
  assign aux_blocked = aux_valid && !aux_ready;

  // Output register: one write per cycle, wb first; addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else if (wb_valid) begin
      RegWrite      <= 1'b1;
      write_address <= wb_addr;
      write_data    <= wb_data;
    end else if (aux_valid) begin
      RegWrite      <= 1'b1;
      write_address <= aux_addr;
      write_data    <= aux_data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (aux_blocked) begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // HOLD persists only while aux keeps being blocked; transfer or withdrawal exits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NORMAL;
      stall_req <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (aux_blocked && wait_cnt == WAIT_LAST) begin
            state     <= HOLD;
            stall_req <= 1'b1;
          end
        end
        HOLD: begin
          if (aux_xfer || !aux_valid) begin
            state     <= NORMAL;
            stall_req <= 1'b0;
          end
        end
        default: begin
          state     <= NORMAL;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed + randomized check of reg_wr_arbiter against a cycle-level reference model.
module tb_reg_wr_arbiter;

  localparam int WIDTH    = 16;
  localparam int N_REGS   = 8;
  localparam int MAX_WAIT = 4;
  localparam int AW       = $clog2(N_REGS);

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             aux_valid;
  logic [AW-1:0]    aux_addr;
  logic [WIDTH-1:0] aux_data;
  logic             aux_ready;
  logic             stall_req;
  logic             RegWrite;
  logic [AW-1:0]    write_address;
  logic [WIDTH-1:0] write_data;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic             m_we, m_stall;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_data;
  int               m_run, m_age;
  logic [WIDTH-1:0] model_rf [N_REGS];
  logic [WIDTH-1:0] dut_rf   [N_REGS];

  reg_wr_arbiter #(.WIDTH(WIDTH), .N_REGS(N_REGS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_ready(aux_ready), .stall_req(stall_req),
    .RegWrite(RegWrite), .write_address(write_address), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_we = 0; m_stall = 0; m_addr = '0; m_data = '0; m_run = 0; m_age = 0;
  endtask

  // One cycle: drive, check the grant, advance the model, sample after the edge.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad);
    logic             blocked, n_we, n_stall;
    logic [AW-1:0]    n_addr;
    logic [WIDTH-1:0] n_data;
    int               run, age;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    #1;
    chk("aux_ready", aux_ready, av && !wv);
    blocked = av && wv;
    n_addr = m_addr; n_data = m_data;
    if (wv)      begin n_we = 1; n_addr = wa; n_data = wd; end
    else if (av) begin n_we = 1; n_addr = aa; n_data = ad; end
    else         n_we = 0;
    run     = blocked ? m_run + 1 : 0;
    n_stall = blocked && (m_stall || run >= MAX_WAIT);
    age     = n_stall ? (m_stall ? m_age + 1 : 0) : 0;
    @(posedge clk); #1;
    m_we = n_we; m_addr = n_addr; m_data = n_data; m_stall = n_stall; m_run = run; m_age = age;
    chk("RegWrite", RegWrite, m_we);
    chk("write_address", write_address, m_addr);
    chk("write_data", write_data, m_data);
    chk("stall_req", stall_req, m_stall);
    if (RegWrite) dut_rf[write_address] = write_data;
    if (m_we)     model_rf[m_addr] = m_data;
  endtask

  initial begin
    logic             pend, wv;
    logic [AW-1:0]    pa;
    logic [WIDTH-1:0] pd;
    int               busy;
    for (int i = 0; i < N_REGS; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    rst = 1; wb_valid = 0; wb_addr = '0; wb_data = '0;
    aux_valid = 0; aux_addr = '0; aux_data = '0;
    m_reset();
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", write_data, 0);
    chk("rst_stall", stall_req, 0);

    // writeback only
    step(1, 5, 16'hBEEF, 0, 0, 0);
    chk("wb_addr", write_address, 5);
    chk("wb_data", write_data, 16'hBEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("wb_drop", RegWrite, 0);

    // same-register collision: wb first, aux next idle cycle
    step(1, 2, 16'h1111, 1, 2, 16'h2222);
    chk("coll_first", write_data, 16'h1111);
    step(0, 0, 0, 1, 2, 16'h2222);
    chk("coll_second", write_data, 16'h2222);
    chk("coll_reg2", dut_rf[2], 16'h2222);
    step(0, 0, 0, 0, 0, 0);

    // starvation: 4 blocked cycles raise stall, in-flight wb once more, then aux wins
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk("starve_pre", stall_req, 0);
      step(1, 1, 16'h0100 + 16'(i), 1, 6, 16'h6666);
    end
    chk("starve_stall", stall_req, 1);
    step(1, 1, 16'h01FF, 1, 6, 16'h6666);
    chk("starve_hold", stall_req, 1);
    step(0, 0, 0, 1, 6, 16'h6666);
    chk("starve_aux_addr", write_address, 6);
    chk("starve_release", stall_req, 0);
    step(0, 0, 0, 0, 0, 0);

    // aux withdraws during HOLD
    for (int i = 0; i < MAX_WAIT; i++) step(1, 4, 16'h4444, 1, 7, 16'h7777);
    chk("wd_hold", stall_req, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("wd_stall", stall_req, 0);
    chk("wd_nowrite", RegWrite, 0);
    chk("wd_reg7", dut_rf[7], 0);

    // back-to-back aux with wb idle
    for (int i = 0; i < N_REGS; i++) begin
      step(0, 0, 0, 1, AW'(i), 16'hA000 + 16'(i));
      chk("b2b_addr", write_address, i);
      chk("b2b_stall", stall_req, 0);
    end
    step(0, 0, 0, 0, 0, 0);

    // reset in the middle of HOLD, pending aux re-arbitrated afterwards
    for (int i = 0; i < MAX_WAIT; i++) step(1, 1, 16'h0BAD, 1, 3, 16'h00AA);
    chk("rh_hold", stall_req, 1);
    #2 rst = 1;
    #1;
    chk("rh_stall", stall_req, 0);
    chk("rh_we", RegWrite, 0);
    chk("rh_cnt", dut.wait_cnt, 0);
    m_reset();
    @(posedge clk); #2 rst = 0;
    step(1, 4, 16'h1234, 1, 3, 16'h00AA);
    step(0, 0, 0, 1, 3, 16'h00AA);
    chk("rh_addr", write_address, 3);
    chk("rh_data", write_data, 16'h00AA);
    chk("rh_reg3", dut_rf[3], 16'h00AA);

    // random traffic obeying the aux hold and pipeline stall contracts
    pend = 0; pa = '0; pd = '0;
    for (int c = 0; c < 600; c++) begin
      busy = (c < 300) ? 60 : 92;
      wv = (m_stall && m_age >= 1) ? 1'b0 : ($urandom_range(0, 99) < busy);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1; pa = AW'($urandom); pd = WIDTH'($urandom);
      end
      step(wv, AW'($urandom), WIDTH'($urandom), pend, pa, pd);
      if (pend && !wv) pend = 0;
    end
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < N_REGS; i++) chk("rf_final", dut_rf[i], model_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
